// File: rtl/ssd_scan.sv
// Four-digit multiplexed seven-segment scan driver with frame-latched shadow data and inter-digit blanking.
// Optional build macro SSD_SCAN_LEADING_ZERO_BLANK_EN blanks segments of leading zero digits.
module ssd_scan #(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        enable,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // With the gap disabled a digit change goes straight back to SHOW.
  localparam logic [1:0] ST_GAP     = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
  localparam logic [7:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  function automatic logic [6:0] hex_seg_n(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [15:0] shadow_data_q, shadow_data_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_start_q, frame_start_d;

  logic        tick_edge;
  logic        load;
  logic        lit;
  logic        seg_blank;
  logic [3:0]  nibble;
  logic [3:0]  an_act;
  logic [6:0]  seg_act;
  logic        dp_act;

  assign tick_edge = tick_in & ~tick_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    tick_d        = tick_in;
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    load          = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_d = 2'd0;
          if (tick_edge) begin
            load    = 1'b1;
            state_d = ST_GAP;
            cnt_d   = 8'd0;
          end
        end
        ST_BLANK: begin
          // Edges landing here are dropped on purpose; only the counter moves the FSM on.
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_SHOW: begin
          if (tick_edge) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_GAP;
            cnt_d   = 8'd0;
            load    = (idx_q == 2'd3);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    shadow_data_d = load ? data  : shadow_data_q;
    shadow_dp_d   = load ? dp_in : shadow_dp_q;
    frame_start_d = load;
  end

  // Outputs are decoded from next-state values so the registered pins line up with the FSM.
  always_comb begin
    lit    = (state_d == ST_SHOW);
    nibble = shadow_data_d[{idx_d, 2'b00} +: 4];
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
    begin
      logic [1:0] top;
      top = 2'd0;
      for (int k = 1; k < 4; k++) begin
        if (shadow_data_d[4*k +: 4] != 4'h0) top = 2'(k);
      end
      seg_blank = (idx_d > top);
    end
`else
    seg_blank = 1'b0;
`endif
    an_act  = lit ? (4'b0001 << idx_d) : 4'b0000;
    seg_act = (lit && !seg_blank) ? ~hex_seg_n(nibble) : 7'h00;
    dp_act  = lit & shadow_dp_d[idx_d];
    an_d    = ACTIVE_LOW ? ~an_act  : an_act;
    seg_d   = ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d    = ACTIVE_LOW ? ~dp_act  : dp_act;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= 8'd0;
      tick_q        <= 1'b0;
      shadow_data_q <= 16'h0000;
      shadow_dp_q   <= 4'h0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
